// File: rtl/pulse_tx_pkg.sv
// Shared types and constants for the pulse transmit path.
// Optional Q output is enabled by defining PULSE_TX_Q_CHANNEL_EN.
package pulse_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLAG_RD,
      ST_FLAG_WAIT,
      ST_FETCH,
      ST_DRAIN,
      ST_DONE
   } tx_state_t;

   localparam int unsigned BASE_ADDR_DEF = 500;
   localparam int unsigned FLAG_ADDR_DEF = 499;

   localparam int I_MSB = 31;
   localparam int I_LSB = 16;
   localparam int Q_MSB = 15;
   localparam int Q_LSB = 0;

endpackage

// File: rtl/pulse_transmitter_if.sv
// Sample-memory read port: address/strobe out, in-order data/valid back.
// Master side is the transmitter, slave side is the memory.
interface pulse_transmitter_if;
   import pulse_tx_pkg::*;

   logic [15:0]          MEM_ADDR;
   logic                 MEM_RD;
   logic [I_MSB:Q_LSB]   MEM_DATA;
   logic                 MEM_VALID;

   modport master (
      output MEM_ADDR,
      output MEM_RD,
      input  MEM_DATA,
      input  MEM_VALID
   );

   modport slave (
      input  MEM_ADDR,
      input  MEM_RD,
      output MEM_DATA,
      output MEM_VALID
   );

endinterface

// File: rtl/tx_prefetch_fifo.sv
// Prefetch FIFO for packed {I,Q} words; head word is visible on pop_data.
// DEPTH must be a power of two.
module tx_prefetch_fifo
   import pulse_tx_pkg::*;
#(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic               AD_CLK,
   input  logic               RESET_N,
   input  logic               push,
   input  logic [I_MSB:0]     push_data,
   input  logic               pop,
   output logic [I_MSB:0]     pop_data,
   output logic [CW-1:0]      count,
   output logic               empty
);

   logic [I_MSB:0] store [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;

   always_ff @(posedge AD_CLK) begin
      if (push)
         store[wr_ptr] <= push_data;
   end

   always_ff @(posedge AD_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign pop_data = store[rd_ptr];
   assign empty    = (count == '0);

endmodule

// File: rtl/pulse_transmitter.sv
// Streams a stored {I,Q} pulse from sample memory to the DAC, one per AD_CLK.
// Define PULSE_TX_Q_CHANNEL_EN to add the DAC_Q_DATA output.
module pulse_transmitter
   import pulse_tx_pkg::*;
#(
   parameter int unsigned BASE_ADDR  = BASE_ADDR_DEF,
   parameter int unsigned FLAG_ADDR  = FLAG_ADDR_DEF,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned PREFILL    = 4,
   parameter logic [15:0] IDLE_CODE  = 16'h0000
) (
   input  logic                AD_CLK,
   input  logic                RESET_N,
   input  logic                TX_START,
   input  logic [15:0]         PULSE_LEN,
   pulse_transmitter_if.master mem,
   output logic [15:0]         DAC_DATA,
   output logic                DAC_VALID,
`ifdef PULSE_TX_Q_CHANNEL_EN
   output logic [15:0]         DAC_Q_DATA,
`endif
   output logic                TX_BUSY,
   output logic                TX_OVER,
   output logic                TX_ERR,
   output logic                TX_UNDERRUN
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   localparam logic [15:0]   BASE_A    = 16'(BASE_ADDR);
   localparam logic [15:0]   FLAG_A    = 16'(FLAG_ADDR);
   localparam logic [CW-1:0] PREFILL_W = CW'(PREFILL);
   localparam logic [CW:0]   DEPTH_W   = (CW+1)'(FIFO_DEPTH);

   tx_state_t     state;
   tx_state_t     state_n;

   logic [15:0]   len;
   logic [15:0]   rd_idx;
   logic [15:0]   out_cnt;
   logic [CW-1:0] outstanding;
   logic          started;

   logic          issue;
   logic          in_xfer;
   logic          push;
   logic          pop;
   logic          can_go;
   logic          underrun;
   logic [CW:0]   occ;

   logic [I_MSB:0] fifo_word;
   logic [CW-1:0]  fifo_count;
   logic           fifo_empty;

   tx_prefetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .AD_CLK    (AD_CLK),
      .RESET_N   (RESET_N),
      .push      (push),
      .push_data (mem.MEM_DATA),
      .pop       (pop),
      .pop_data  (fifo_word),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   // Returns are only taken while reads are owed, so stale data after
   // an abort never lands in the FIFO.
   assign in_xfer  = (state == ST_FETCH) || (state == ST_DRAIN);
   assign push     = in_xfer && mem.MEM_VALID
                     && (outstanding != '0);
   assign occ      = {1'b0, fifo_count} + {1'b0, outstanding};
   assign can_go   = started || (fifo_count >= PREFILL_W)
                     || (rd_idx == len);
   assign pop      = in_xfer && !fifo_empty && can_go
                     && (out_cnt != len);
   assign underrun = in_xfer && started && fifo_empty
                     && (out_cnt != len);

   always_comb begin
      state_n      = state;
      issue        = 1'b0;
      TX_OVER      = 1'b0;
      mem.MEM_RD   = 1'b0;
      mem.MEM_ADDR = '0;
      unique case (state)
         ST_IDLE: begin
            if (TX_START)
               state_n = (PULSE_LEN == '0) ? ST_DONE
                                           : ST_FLAG_RD;
         end
         ST_FLAG_RD: begin
            mem.MEM_RD   = 1'b1;
            mem.MEM_ADDR = FLAG_A;
            state_n      = ST_FLAG_WAIT;
         end
         ST_FLAG_WAIT: begin
            if (mem.MEM_VALID)
               state_n = mem.MEM_DATA[0] ? ST_FETCH
                                         : ST_DONE;
         end
         ST_FETCH: begin
            if (rd_idx == len) begin
               state_n = ST_DRAIN;
            end else if (occ < DEPTH_W) begin
               issue        = 1'b1;
               mem.MEM_RD   = 1'b1;
               mem.MEM_ADDR = BASE_A + rd_idx;
            end
         end
         ST_DRAIN: begin
            if (out_cnt == len)
               state_n = ST_DONE;
         end
         ST_DONE: begin
            TX_OVER = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge AD_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= ST_IDLE;
         len         <= '0;
         rd_idx      <= '0;
         out_cnt     <= '0;
         outstanding <= '0;
         started     <= 1'b0;
         DAC_DATA    <= IDLE_CODE;
         DAC_VALID   <= 1'b0;
`ifdef PULSE_TX_Q_CHANNEL_EN
         DAC_Q_DATA  <= IDLE_CODE;
`endif
         TX_BUSY     <= 1'b0;
         TX_ERR      <= 1'b0;
         TX_UNDERRUN <= 1'b0;
      end else begin
         state <= state_n;

         if (state == ST_IDLE && TX_START) begin
            len         <= PULSE_LEN;
            rd_idx      <= '0;
            out_cnt     <= '0;
            outstanding <= '0;
            started     <= 1'b0;
            TX_ERR      <= 1'b0;
            TX_UNDERRUN <= 1'b0;
            TX_BUSY     <= 1'b1;
         end

         if (state == ST_FLAG_WAIT && mem.MEM_VALID
             && !mem.MEM_DATA[0])
            TX_ERR <= 1'b1;

         if (issue)
            rd_idx <= rd_idx + 16'd1;

         case ({issue, push})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase

         // DAC shows IDLE_CODE on every cycle without a fresh pop.
         if (pop) begin
            DAC_DATA  <= fifo_word[I_MSB:I_LSB];
            DAC_VALID <= 1'b1;
`ifdef PULSE_TX_Q_CHANNEL_EN
            DAC_Q_DATA <= fifo_word[Q_MSB:Q_LSB];
`endif
            out_cnt   <= out_cnt + 16'd1;
            started   <= 1'b1;
         end else begin
            DAC_DATA  <= IDLE_CODE;
            DAC_VALID <= 1'b0;
`ifdef PULSE_TX_Q_CHANNEL_EN
            DAC_Q_DATA <= IDLE_CODE;
`endif
         end

         if (underrun)
            TX_UNDERRUN <= 1'b1;

         if (state == ST_DONE)
            TX_BUSY <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pulse_transmitter.sv
// Scoreboard bench for pulse_transmitter with a fixed-latency memory model.
// Expected read addresses and DAC words are queued at start, popped on output.
module tb_pulse_transmitter;
   import pulse_tx_pkg::*;

   localparam logic [15:0] IDLE = 16'h0000;

   logic        AD_CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        TX_START = 1'b0;
   logic [15:0] PULSE_LEN = '0;
   logic [15:0] DAC_DATA;
   logic        DAC_VALID;
`ifdef PULSE_TX_Q_CHANNEL_EN
   logic [15:0] DAC_Q_DATA;
`endif
   logic        TX_BUSY;
   logic        TX_OVER;
   logic        TX_ERR;
   logic        TX_UNDERRUN;

   pulse_transmitter_if mif();

   pulse_transmitter #(
      .FIFO_DEPTH (4),
      .PREFILL    (4),
      .IDLE_CODE  (IDLE)
   ) dut (
      .AD_CLK      (AD_CLK),
      .RESET_N     (RESET_N),
      .TX_START    (TX_START),
      .PULSE_LEN   (PULSE_LEN),
      .mem         (mif),
      .DAC_DATA    (DAC_DATA),
      .DAC_VALID   (DAC_VALID),
`ifdef PULSE_TX_Q_CHANNEL_EN
      .DAC_Q_DATA  (DAC_Q_DATA),
`endif
      .TX_BUSY     (TX_BUSY),
      .TX_OVER     (TX_OVER),
      .TX_ERR      (TX_ERR),
      .TX_UNDERRUN (TX_UNDERRUN)
   );

   always #5 AD_CLK = ~AD_CLK;

   typedef struct {
      int          due;
      logic [31:0] d;
   } ret_t;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          lat = 2;
   int          over_cnt = 0;
   int          over_cyc = 0;
   int          dac_seen = 0;
   int          gap_cnt = 0;
   int          first_v = -1;
   int          last_v = -1;
   logic [31:0] mem_arr [0:1023];
   logic [15:0] exp_addr [$];
   logic [31:0] exp_dac [$];
   ret_t        rq [$];
   logic [31:0] w;
   logic [15:0] a;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(posedge AD_CLK) cyc <= cyc + 1;

   // Memory model, read-address checker and DAC monitor.
   always @(negedge AD_CLK) begin
      mif.MEM_VALID = 1'b0;
      mif.MEM_DATA  = '0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         mif.MEM_VALID = 1'b1;
         mif.MEM_DATA  = rq[0].d;
         void'(rq.pop_front());
      end
      if (mif.MEM_RD === 1'b1) begin
         if (exp_addr.size() == 0) begin
            chk("rd_extra", 32'(mif.MEM_ADDR), 32'hFFFF_FFFF);
         end else begin
            a = exp_addr.pop_front();
            chk("rd_addr", 32'(mif.MEM_ADDR), 32'(a));
         end
         rq.push_back('{cyc + lat, mem_arr[mif.MEM_ADDR[9:0]]});
      end
      if (DAC_VALID === 1'b1) begin
         dac_seen++;
         if (first_v < 0)
            first_v = cyc;
         last_v = cyc;
         if (exp_dac.size() == 0) begin
            chk("dac_extra", 32'(DAC_DATA), 32'hFFFF_FFFF);
         end else begin
            w = exp_dac.pop_front();
            chk("dac_i", 32'(DAC_DATA), 32'(w[31:16]));
`ifdef PULSE_TX_Q_CHANNEL_EN
            chk("dac_q", 32'(DAC_Q_DATA), 32'(w[15:0]));
`endif
         end
      end else if (TX_BUSY === 1'b1 && first_v >= 0) begin
         gap_cnt++;
         chk("dac_idle", 32'(DAC_DATA), 32'(IDLE));
      end
      if (TX_OVER === 1'b1) begin
         over_cnt++;
         over_cyc = cyc;
      end
   end

   task automatic start(input logic [15:0] len,
                        input bit flag);
      first_v = -1;
      last_v  = -1;
      gap_cnt = 0;
      if (len != 0)
         exp_addr.push_back(16'(FLAG_ADDR_DEF));
      if (flag)
         for (int i = 0; i < int'(len); i++) begin
            exp_addr.push_back(16'(BASE_ADDR_DEF + i));
            exp_dac.push_back(mem_arr[BASE_ADDR_DEF + i]);
         end
      @(negedge AD_CLK);
      TX_START  = 1'b1;
      PULSE_LEN = len;
      @(negedge AD_CLK);
      TX_START  = 1'b0;
   endtask

   task automatic wait_over(input int ov0);
      int g = 0;
      while (over_cnt == ov0 && g < 3000) begin
         @(negedge AD_CLK);
         g++;
      end
      repeat (3) @(negedge AD_CLK);
      chk("over_cnt", 32'(over_cnt - ov0), 32'd1);
      chk("dac_left", 32'(exp_dac.size()), 32'd0);
      chk("rd_left", 32'(exp_addr.size()), 32'd0);
      chk("busy_end", 32'(TX_BUSY), 32'd0);
   endtask

   task automatic load(input logic [31:0] flag);
      mem_arr[FLAG_ADDR_DEF] = flag;
   endtask

   initial begin
      int ov0;
      int seen0;
      int g;
      mif.MEM_VALID = 1'b0;
      mif.MEM_DATA  = '0;
      for (int i = 0; i < 1024; i++)
         mem_arr[i] = {16'(i), 16'(~i)};

      repeat (3) @(negedge AD_CLK);
      chk("rst_dac", 32'(DAC_DATA), 32'(IDLE));
      chk("rst_dvalid", 32'(DAC_VALID), 32'd0);
      chk("rst_busy", 32'(TX_BUSY), 32'd0);
      chk("rst_over", 32'(TX_OVER), 32'd0);
      chk("rst_err", 32'(TX_ERR), 32'd0);
      chk("rst_urun", 32'(TX_UNDERRUN), 32'd0);
      chk("rst_rd", 32'(mif.MEM_RD), 32'd0);
      chk("rst_addr", 32'(mif.MEM_ADDR), 32'd0);
      RESET_N = 1'b1;
      repeat (2) @(negedge AD_CLK);

      // basic 4-sample pulse, latency 2
      load(32'd1);
      mem_arr[500] = 32'h1111_AAAA;
      mem_arr[501] = 32'h2222_BBBB;
      mem_arr[502] = 32'h3333_CCCC;
      mem_arr[503] = 32'h4444_DDDD;
      lat = 2;
      ov0 = over_cnt;
      start(16'd4, 1'b1);
      wait_over(ov0);
      chk("t1_urun", 32'(TX_UNDERRUN), 32'd0);
      chk("t1_err", 32'(TX_ERR), 32'd0);
      chk("t1_span", 32'(last_v - first_v), 32'd3);
      chk("t1_over_at", 32'(over_cyc - last_v), 32'd1);

      // flag word clear
      load(32'h2);
      ov0   = over_cnt;
      seen0 = dac_seen;
      start(16'd5, 1'b0);
      wait_over(ov0);
      chk("t2_err", 32'(TX_ERR), 32'd1);
      chk("t2_nodac", 32'(dac_seen - seen0), 32'd0);

      // zero-length pulse
      ov0 = over_cnt;
      start(16'd0, 1'b0);
      chk("t3_over", 32'(TX_OVER), 32'd1);
      chk("t3_busy", 32'(TX_BUSY), 32'd1);
      chk("t3_errclr", 32'(TX_ERR), 32'd0);
      @(negedge AD_CLK);
      chk("t3_busy_off", 32'(TX_BUSY), 32'd0);
      chk("t3_over_off", 32'(TX_OVER), 32'd0);
      repeat (2) @(negedge AD_CLK);
      chk("t3_over_cnt", 32'(over_cnt - ov0), 32'd1);

      // slow memory forces underrun
      load(32'd1);
      for (int i = 0; i < 16; i++)
         mem_arr[500 + i] = {16'(16'h1000 + i), 16'(16'hF000 + i)};
      lat = 6;
      ov0 = over_cnt;
      start(16'd16, 1'b1);
      wait_over(ov0);
      chk("t4_urun", 32'(TX_UNDERRUN), 32'd1);
      chk("t4_gaps", 32'(gap_cnt > 0), 32'd1);

      // reset in the middle of a 10-sample pulse
      lat = 2;
      for (int i = 0; i < 10; i++)
         mem_arr[500 + i] = {16'(16'h5000 + i), 16'(16'h0A00 + i)};
      ov0   = over_cnt;
      seen0 = dac_seen;
      start(16'd10, 1'b1);
      g = 0;
      while (dac_seen < seen0 + 3 && g < 500) begin
         @(negedge AD_CLK);
         g++;
      end
      chk("t5_reached", 32'(dac_seen >= seen0 + 3), 32'd1);
      #1 RESET_N = 1'b0;
      #1;
      chk("t5_dvalid", 32'(DAC_VALID), 32'd0);
      chk("t5_dac", 32'(DAC_DATA), 32'(IDLE));
      chk("t5_busy", 32'(TX_BUSY), 32'd0);
      chk("t5_rd", 32'(mif.MEM_RD), 32'd0);
      chk("t5_addr", 32'(mif.MEM_ADDR), 32'd0);
      exp_addr.delete();
      exp_dac.delete();
      repeat (3) @(negedge AD_CLK);
      RESET_N = 1'b1;
      repeat (12) @(negedge AD_CLK);
      chk("t5_no_over", 32'(over_cnt - ov0), 32'd0);
      chk("t5_idle_busy", 32'(TX_BUSY), 32'd0);
      ov0 = over_cnt;
      start(16'd3, 1'b1);
      wait_over(ov0);

      // repeated start requests while busy
      for (int i = 0; i < 8; i++)
         mem_arr[500 + i] = {16'(16'h7000 + i), 16'(16'h0700 + i)};
      ov0 = over_cnt;
      start(16'd8, 1'b1);
      repeat (2) @(negedge AD_CLK);
      TX_START  = 1'b1;
      PULSE_LEN = 16'd3;
      @(negedge AD_CLK);
      TX_START  = 1'b0;
      repeat (3) @(negedge AD_CLK);
      TX_START  = 1'b1;
      @(negedge AD_CLK);
      TX_START  = 1'b0;
      wait_over(ov0);
      chk("t6_urun", 32'(TX_UNDERRUN), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pulse_transmitter.md
Name: pulse_transmitter

Overview:
- Transmit-side counterpart of the IQ capture path. Reads a pulse waveform (packed {I,Q} 32-bit words) from the shared sample memory and streams it to the DAC at one sample per AD_CLK.
- Checks the ready-flag word first, prefetches samples into a small FIFO, then drives DAC_DATA.
- Sits between the host-loaded sample memory and the DAC front end; all logic runs in the AD_CLK domain.

Parameters:
- BASE_ADDR, 500, memory address of sample 0.
- FLAG_ADDR, 499, address of the ready-flag word; bit0=1 means the waveform is valid.
- FIFO_DEPTH, 8, prefetch FIFO entries (power of 2, at least 4).
- PREFILL, 4, FIFO occupancy required before streaming starts (1..FIFO_DEPTH).
- IDLE_CODE, 16'h0000, DAC value driven when not streaming.

Ports:
- AD_CLK  in  1  sample clock.
- RESET_N  in  1  async active-low reset.
- TX_START  in  1  start request; sampled only in IDLE.
- PULSE_LEN  in  16  number of samples; latched on start.
- MEM_ADDR  out  16  read address.
- MEM_RD  out  1  one-cycle read strobe.
- MEM_DATA  in  32  read data {I[31:16],Q[15:0]}.
- MEM_VALID  in  1  read data valid; in order, latency at least 1.
- DAC_DATA  out  16  I sample to DAC.
- DAC_VALID  out  1  DAC_DATA holds a waveform sample.
- TX_BUSY  out  1  high from start accept until TX_OVER.
- TX_OVER  out  1  one-cycle pulse at end of transfer.
- TX_ERR  out  1  sticky: flag word not set.
- TX_UNDERRUN  out  1  sticky: FIFO ran empty mid-pulse.

Behaviour:
- Interface: reset RESET_N, asynchronous, active-low; clock AD_CLK.
- Reset values:
  - MEM_RD=0, MEM_ADDR=0.
  - DAC_DATA=IDLE_CODE, DAC_VALID=0.
  - TX_BUSY=0, TX_OVER=0, TX_ERR=0, TX_UNDERRUN=0.
  - FIFO empty, all counters 0, state IDLE.
- Reset asserted mid-transfer aborts immediately. No TX_OVER is issued, and in-flight MEM_VALID returns after reset release are ignored.
- States are IDLE, FLAG_RD, FLAG_WAIT, FETCH, DRAIN, DONE.
- IDLE:
  - TX_START=1 latches len=PULSE_LEN, clears TX_ERR and TX_UNDERRUN, clears rd_idx and out_cnt, and sets TX_BUSY.
  - Next state: FLAG_RD, or DONE if len==0.
  - TX_START outside IDLE is ignored.
- FLAG_RD: MEM_RD=1 and MEM_ADDR=FLAG_ADDR for one cycle, then FLAG_WAIT.
- FLAG_WAIT:
  - On MEM_VALID with MEM_DATA[0]=1, go to FETCH.
  - On MEM_VALID with MEM_DATA[0]=0, set TX_ERR and go to DONE. No samples are read and DAC_VALID stays 0.
- FETCH (read issue):
  - Issue a read when rd_idx<len and (fifo_count+outstanding)<FIFO_DEPTH.
  - MEM_RD=1 and MEM_ADDR=BASE_ADDR+rd_idx, truncated to 16 bits (wraps mod 2^16), then rd_idx++.
  - Pipelined reads allowed, at most one per cycle.
  - Each MEM_VALID pushes MEM_DATA into the FIFO and decrements outstanding. Overflow is impossible by construction.
- Streaming:
  - Starts in the first cycle where fifo_count>=PREFILL or rd_idx==len.
  - Once started, each cycle with the FIFO non-empty pops one word, registers DAC_DATA<=word[31:16], DAC_VALID<=1, and increments out_cnt.
  - Latency is one cycle from pop to DAC output.
  - Push and pop in the same cycle leave the count unchanged; pop uses the head entry.
- Underrun: if the FIFO is empty while out_cnt<len after streaming has started, set TX_UNDERRUN, drive DAC_DATA<=IDLE_CODE and DAC_VALID<=0. Resume as data arrives; no samples are dropped.
- After rd_idx==len, FETCH moves to DRAIN. DRAIN continues streaming until out_cnt==len, then goes to DONE.
- DONE: one cycle with TX_OVER=1, TX_BUSY<=0, DAC_DATA<=IDLE_CODE, DAC_VALID<=0, then IDLE. TX_START seen in the DONE cycle is ignored.
- Counters: rd_idx, out_cnt and len are 16-bit; len=65535 is supported.

Optional Feature:
- Macro: PULSE_TX_Q_CHANNEL_EN.
- When defined: adds output port DAC_Q_DATA (16 bits), driven with word[15:0] in the same cycle as DAC_DATA. Reset value and idle value are IDLE_CODE.
- When undefined: the port is absent and the Q half of each word is discarded.

Decomposition:
- Shared package pulse_tx_pkg holds:
  - state enum tx_state_t;
  - localparams BASE_ADDR_DEF=500 and FLAG_ADDR_DEF=499;
  - IQ word slicing constants (I_MSB=31, I_LSB=16, Q_MSB=15, Q_LSB=0).
- One sub-module, tx_prefetch_fifo: synchronous FIFO, DEPTH parameter, 32-bit data, push/pop/count/empty, async active-low reset.

Test Plan:
- Flag=1, PULSE_LEN=4, mem[500..503]={0x1111_AAAA,0x2222_BBBB,0x3333_CCCC,0x4444_DDDD}, latency 2 -> reads 499,500..503; DAC_DATA 0x1111,0x2222,0x3333,0x4444 on 4 consecutive cycles; TX_OVER one cycle after the last sample; TX_UNDERRUN=0.
- Flag word=0 -> exactly one read (addr 499); TX_ERR=1; TX_OVER pulses; DAC_VALID never 1.
- PULSE_LEN=0 -> no MEM_RD; TX_OVER the cycle after start; TX_BUSY high for 1 cycle.
- Latency 6, PULSE_LEN=16, FIFO_DEPTH=4 -> TX_UNDERRUN=1; all 16 samples still output in order; DAC_VALID gaps show IDLE_CODE.
- RESET_N low at out_cnt=3 of 10 -> all outputs at reset values; new start after release reads 499 again.
- TX_START asserted again while TX_BUSY=1 -> ignored; exactly PULSE_LEN samples and a single TX_OVER.
